// File: rtl/clk_rst_pkg.sv
// Shared types, default parameters and helpers for the clk_sys reset
// sequencer and its timebase stages.
package clk_rst_pkg;

  // Sequencer states: hold everything in reset, release one by one, run.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  localparam int DEF_CLK_MHZ  = 100;
  localparam int DEF_TICK_DIV = 1000;
  localparam int DEF_NUM_RST  = 2;
  localparam int DEF_RST_HOLD = 16;
  localparam int DEF_RST_GAP  = 8;

  // Width of a counter that must hold values 0..n-1; never narrower than 1.
  function automatic int cnt_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/clk_rst_seq_tick_div.sv
// One divide-by-DIV stage of the cascaded timebase. wrap_o is the
// combinational "this stage wraps on this edge" term that feeds the next
// stage, so all strobes of a cascade land in the same cycle.
module tick_div
  import clk_rst_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic clr_i,
  input  logic en,
  input  logic in_strobe,
  output logic out_strobe,
  output logic wrap_o
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          step_s;

  assign step_s     = en & in_strobe;
  assign wrap_o     = step_s & (cnt_q == LAST);
  assign out_strobe = out_q;

  // Next count and strobe: clear wins, then wrap, then plain advance; frozen otherwise.
  always_comb begin
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
      out_d = 1'b0;
    end else if (wrap_o) begin
      cnt_d = {CW{1'b0}};
      out_d = 1'b1;
    end else if (step_s) begin
      cnt_d = cnt_q + CW'(1);
      out_d = 1'b0;
    end else begin
      cnt_d = cnt_q;
      out_d = 1'b0;
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer and us/ms/s timebase for the clk_sys domain. Subsystem
// resets are released in index order after a hold time, spaced by a gap;
// soft_rst restarts the whole sequence and clears the timebase.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int CLK_MHZ  = DEF_CLK_MHZ,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int NUM_RST  = DEF_NUM_RST,
  parameter int RST_HOLD = DEF_RST_HOLD,
  parameter int RST_GAP  = DEF_RST_GAP
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               soft_rst,
  input  logic               tick_en,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic               pulse_us,
  output logic               pulse_ms,
  output logic               pulse_s
);

  localparam int            HW        = cnt_w(RST_HOLD);
  localparam int            GW        = cnt_w(RST_GAP);
  localparam int            IW        = cnt_w(NUM_RST);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(RST_GAP - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_RST - 1);

  seq_state_e         state_q, state_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]      rel_idx_q, rel_idx_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic               ready_q, ready_d;
  logic               us_en_s, us_wrap_s, ms_wrap_s, s_wrap_s;

  assign rst_out = rst_out_q;
  assign ready   = ready_q;

  // State register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; soft reset returns to HOLD from anywhere.
  always_comb begin
    state_d = state_q;
    if (soft_rst) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = (NUM_RST == 1) ? RUN : REL;
          end else begin
            state_d = HOLD;
          end
        end
        REL: begin
          if ((gap_cnt_q == GAP_LAST) && (rel_idx_q == LAST_IDX)) begin
            state_d = RUN;
          end else begin
            state_d = REL;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = HOLD;
      endcase
    end
  end

  // Counters, release index and next values of the registered outputs.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rel_idx_d  = rel_idx_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    if (soft_rst) begin
      hold_cnt_d = {HW{1'b0}};
      gap_cnt_d  = {GW{1'b0}};
      rel_idx_d  = {IW{1'b0}};
      rst_out_d  = {NUM_RST{1'b1}};
      ready_d    = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d   = {HW{1'b0}};
            gap_cnt_d    = {GW{1'b0}};
            rel_idx_d    = IW'(1);
            rst_out_d[0] = 1'b0;
            ready_d      = (NUM_RST == 1);
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
        REL: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d            = {GW{1'b0}};
            rst_out_d[rel_idx_q] = 1'b0;
            if (rel_idx_q == LAST_IDX) begin
              ready_d = 1'b1;
            end else begin
              rel_idx_d = rel_idx_q + IW'(1);
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        RUN: begin
          ready_d = 1'b1;
        end
        default: begin
          rst_out_d = {NUM_RST{1'b1}};
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers; everything held in reset while rst is high.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= {HW{1'b0}};
      gap_cnt_q  <= {GW{1'b0}};
      rel_idx_q  <= {IW{1'b0}};
      rst_out_q  <= {NUM_RST{1'b1}};
      ready_q    <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rel_idx_q  <= rel_idx_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
    end
  end

  // The timebase runs only once the first subsystem is out of reset.
  assign us_en_s = tick_en & ~rst_out_q[0];

  tick_div #(.DIV(CLK_MHZ)) u_us (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .clr_i      (soft_rst),
    .en         (us_en_s),
    .in_strobe  (1'b1),
    .out_strobe (pulse_us),
    .wrap_o     (us_wrap_s)
  );

  tick_div #(.DIV(TICK_DIV)) u_ms (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .clr_i      (soft_rst),
    .en         (us_en_s),
    .in_strobe  (us_wrap_s),
    .out_strobe (pulse_ms),
    .wrap_o     (ms_wrap_s)
  );

  tick_div #(.DIV(TICK_DIV)) u_s (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .clr_i      (soft_rst),
    .en         (us_en_s),
    .in_strobe  (ms_wrap_s),
    .out_strobe (pulse_s),
    .wrap_o     (s_wrap_s)
  );

endmodule
